// File: rtl/fifo_rptr_sync_flags_if.sv
// Handshake bundle between the FIFO write-side logic and the read-pointer receiver.
// The master drives the pointers and the error clear; the slave returns the synced pointer and flags.
interface fifo_rptr_sync_flags_if #(
  parameter int ADDR_SIZE = 8
);
  logic [ADDR_SIZE:0] r_ptr_gray_i;
  logic [ADDR_SIZE:0] w_ptr_bin_i;
  logic               w_err_clr_i;
  logic [ADDR_SIZE:0] w_r_ptr_gray_o;
  logic [ADDR_SIZE:0] w_r_ptr_bin_o;
  logic               w_r_ptr_upd_o;
  logic [ADDR_SIZE:0] w_free_o;
  logic               w_full_o;
  logic               w_almost_full_o;
  logic               w_sync_err_o;
  logic               w_overrun_o;

  modport master (
    output r_ptr_gray_i, w_ptr_bin_i, w_err_clr_i,
    input  w_r_ptr_gray_o, w_r_ptr_bin_o, w_r_ptr_upd_o, w_free_o,
           w_full_o, w_almost_full_o, w_sync_err_o, w_overrun_o
  );

  modport slave (
    input  r_ptr_gray_i, w_ptr_bin_i, w_err_clr_i,
    output w_r_ptr_gray_o, w_r_ptr_bin_o, w_r_ptr_upd_o, w_free_o,
           w_full_o, w_almost_full_o, w_sync_err_o, w_overrun_o
  );
endinterface

// File: rtl/fifo_rptr_sync_flags.sv
// Write-domain receiver for the Gray read pointer: flop-chain sync, Gray->binary,
// pessimistic full / almost-full / free count, and sticky Gray-jump / overrun flags.
module fifo_rptr_sync_flags #(
  parameter int ADDR_SIZE       = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int ALMOST_FULL_THR = 4
) (
  input  logic                    w_clk_i,
  input  logic                    w_rst_i,
  fifo_rptr_sync_flags_if.slave   bus
);
  localparam int              AW     = ADDR_SIZE;
  localparam int              SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [AW:0]     DEPTH  = (AW + 1)'(1) << AW;
  localparam logic [AW:0]     AF_THR = (AW + 1)'(ALMOST_FULL_THR);
  localparam logic [AW:0]     ONE    = (AW + 1)'(1);

  logic [AW:0] sync_q [SYNC_N];
  logic [AW:0] gray_sync;
  logic [AW:0] bin_nxt;
  logic [AW:0] r_bin_q;
  logic        upd_q;
  logic [AW:0] prev_gray_q;
  logic        chk_en_q;
  logic        sync_err_q;
  logic        overrun_q;
  logic [AW:0] used;
  logic [AW:0] gray_diff;
  logic        gray_jump;
  logic        full;
  logic        over;
  logic [AW:0] free;

  assign gray_sync = sync_q[SYNC_N-1];

  always_ff @(posedge w_clk_i or negedge w_rst_i) begin
    if (!w_rst_i) begin
      for (int k = 0; k < SYNC_N; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= bus.r_ptr_gray_i;
      for (int k = 1; k < SYNC_N; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    bin_nxt = '0;
    for (int i = 0; i <= AW; i++) bin_nxt[i] = ^(gray_sync >> i);
  end

  assign gray_diff = prev_gray_q ^ gray_sync;
  assign gray_jump = chk_en_q && (|(gray_diff & (gray_diff - ONE)));

  // Flags use the registered pointer, so a stale value can only under-report free space.
  assign used = bus.w_ptr_bin_i - r_bin_q;
  assign full = (used >= DEPTH);
  assign over = (used > DEPTH);
  assign free = full ? '0 : (DEPTH - used);

  always_ff @(posedge w_clk_i or negedge w_rst_i) begin
    if (!w_rst_i) begin
      r_bin_q     <= '0;
      upd_q       <= 1'b0;
      prev_gray_q <= '0;
      chk_en_q    <= 1'b0;
      sync_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      r_bin_q     <= bin_nxt;
      upd_q       <= (bin_nxt != r_bin_q);
      prev_gray_q <= gray_sync;
      chk_en_q    <= 1'b1;
      if (gray_jump)            sync_err_q <= 1'b1;
      else if (bus.w_err_clr_i) sync_err_q <= 1'b0;
      if (over)                 overrun_q  <= 1'b1;
      else if (bus.w_err_clr_i) overrun_q  <= 1'b0;
    end
  end

  assign bus.w_r_ptr_gray_o  = gray_sync;
  assign bus.w_r_ptr_bin_o   = r_bin_q;
  assign bus.w_r_ptr_upd_o   = upd_q;
  assign bus.w_free_o        = free;
  assign bus.w_full_o        = full;
  assign bus.w_almost_full_o = (free <= AF_THR);
  assign bus.w_sync_err_o    = sync_err_q;
  assign bus.w_overrun_o     = overrun_q;
endmodule

// File: tb/tb_fifo_rptr_sync_flags.sv
// Directed bench for fifo_rptr_sync_flags at ADDR_SIZE=3 (DEPTH=8), SYNC_STAGES=2, threshold 4.
module tb_fifo_rptr_sync_flags;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  fifo_rptr_sync_flags_if #(.ADDR_SIZE(3)) bus ();

  fifo_rptr_sync_flags #(
    .ADDR_SIZE(3), .SYNC_STAGES(2), .ALMOST_FULL_THR(4)
  ) dut (
    .w_clk_i (clk),
    .w_rst_i (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r_gray;
    logic [3:0] w_ptr;
    logic [3:0] exp_free;
    logic       exp_full;
    logic       exp_af;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.r_ptr_gray_i = '0;
    bus.w_ptr_bin_i  = '0;
    bus.w_err_clr_i  = 1'b0;
    #7;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    // r_gray, w_ptr, free, full, almost_full  (r bin = gray decoded)
    vecs[0]  = '{4'b0000, 4'd0,  4'd8, 1'b0, 1'b0};
    vecs[1]  = '{4'b0000, 4'd4,  4'd4, 1'b0, 1'b1};
    vecs[2]  = '{4'b0000, 4'd3,  4'd5, 1'b0, 1'b0};
    vecs[3]  = '{4'b0000, 4'd8,  4'd0, 1'b1, 1'b1};
    vecs[4]  = '{4'b1110, 4'd3,  4'd0, 1'b1, 1'b1};  // r=11, wrap: used 8
    vecs[5]  = '{4'b1110, 4'd4,  4'd0, 1'b1, 1'b1};  // used 9
    vecs[6]  = '{4'b0111, 4'd7,  4'd6, 1'b0, 1'b0};  // r=5
    vecs[7]  = '{4'b1000, 4'd1,  4'd6, 1'b0, 1'b0};  // r=15, used 2
    vecs[8]  = '{4'b1000, 4'd3,  4'd4, 1'b0, 1'b1};  // r=15, used 4
    vecs[9]  = '{4'b0101, 4'd6,  4'd8, 1'b0, 1'b0};  // r=6
    vecs[10] = '{4'b0101, 4'd5,  4'd0, 1'b1, 1'b1};  // r=6, used 15

    rst_n = 1'b0;
    bus.r_ptr_gray_i = '0;
    bus.w_ptr_bin_i  = '0;
    bus.w_err_clr_i  = 1'b0;
    #12;
    chk("rst_gray",  int'(bus.w_r_ptr_gray_o), 0);
    chk("rst_bin",   int'(bus.w_r_ptr_bin_o), 0);
    chk("rst_upd",   int'(bus.w_r_ptr_upd_o), 0);
    chk("rst_free",  int'(bus.w_free_o), 8);
    chk("rst_full",  int'(bus.w_full_o), 0);
    chk("rst_af",    int'(bus.w_almost_full_o), 0);
    chk("rst_serr",  int'(bus.w_sync_err_o), 0);
    chk("rst_ovr",   int'(bus.w_overrun_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // Latency: change before edge N
    bus.r_ptr_gray_i = 4'b0001;
    step();                                      // N
    chk("lat_gray_N", int'(bus.w_r_ptr_gray_o), 0);
    step();                                      // N+1
    chk("lat_gray_N1", int'(bus.w_r_ptr_gray_o), 1);
    chk("lat_bin_N1",  int'(bus.w_r_ptr_bin_o), 0);
    chk("lat_upd_N1",  int'(bus.w_r_ptr_upd_o), 0);
    bus.w_ptr_bin_i = 4'd1;                      // write alongside pointer update
    #1;
    chk("simul_free_pre", int'(bus.w_free_o), 7);
    step();                                      // N+2
    chk("lat_bin_N2", int'(bus.w_r_ptr_bin_o), 1);
    chk("lat_upd_N2", int'(bus.w_r_ptr_upd_o), 1);
    chk("simul_free_post", int'(bus.w_free_o), 8);
    chk("lat_serr", int'(bus.w_sync_err_o), 0);
    step();                                      // N+3
    chk("lat_upd_N3", int'(bus.w_r_ptr_upd_o), 0);

    // Table-driven flag vectors
    for (int i = 0; i < 11; i++) begin
      bus.r_ptr_gray_i = vecs[i].r_gray;
      bus.w_ptr_bin_i  = vecs[i].w_ptr;
      step();
      step();
      step();
      chk($sformatf("vec%0d_free", i), int'(bus.w_free_o), int'(vecs[i].exp_free));
      chk($sformatf("vec%0d_full", i), int'(bus.w_full_o), int'(vecs[i].exp_full));
      chk($sformatf("vec%0d_af", i),   int'(bus.w_almost_full_o), int'(vecs[i].exp_af));
    end

    // Overrun with wrap, set-vs-clear priority
    do_reset();
    bus.r_ptr_gray_i = 4'b1110;                  // r bin 1011
    step();
    step();
    step();
    bus.w_err_clr_i = 1'b1;
    step();
    bus.w_err_clr_i = 1'b0;
    chk("ovr_bin", int'(bus.w_r_ptr_bin_o), 11);
    bus.w_ptr_bin_i = 4'b0011;
    #1;
    chk("ovr_full8", int'(bus.w_full_o), 1);
    step();
    chk("ovr_not_yet", int'(bus.w_overrun_o), 0);
    bus.w_ptr_bin_i = 4'b0100;
    #1;
    chk("ovr_free9", int'(bus.w_free_o), 0);
    chk("ovr_pre", int'(bus.w_overrun_o), 0);
    step();
    chk("ovr_set", int'(bus.w_overrun_o), 1);
    bus.w_err_clr_i = 1'b1;
    step();
    chk("ovr_set_wins", int'(bus.w_overrun_o), 1);
    bus.w_ptr_bin_i = 4'b0011;
    step();
    bus.w_err_clr_i = 1'b0;
    chk("ovr_cleared", int'(bus.w_overrun_o), 0);

    // Illegal Gray jump 0000 -> 0011
    do_reset();
    bus.r_ptr_gray_i = 4'b0011;
    step();                                      // N
    step();                                      // N+1
    chk("serr_gray", int'(bus.w_r_ptr_gray_o), 3);
    chk("serr_pre", int'(bus.w_sync_err_o), 0);
    bus.w_err_clr_i = 1'b1;
    step();                                      // N+2
    chk("serr_set_wins", int'(bus.w_sync_err_o), 1);
    chk("serr_bin", int'(bus.w_r_ptr_bin_o), 2);
    step();                                      // N+3
    chk("serr_cleared", int'(bus.w_sync_err_o), 0);
    bus.w_err_clr_i = 1'b0;
    step();
    chk("serr_stays0", int'(bus.w_sync_err_o), 0);

    // Async reset mid-stream discards the in-flight sample
    do_reset();
    step();
    bus.r_ptr_gray_i = 4'b0001;
    step();                                      // stage 0 holds new value
    bus.r_ptr_gray_i = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gray", int'(bus.w_r_ptr_gray_o), 0);
    chk("arst_bin",  int'(bus.w_r_ptr_bin_o), 0);
    #3;
    rst_n = 1'b1;
    begin
      int upd_seen;
      int gray_seen;
      upd_seen  = 0;
      gray_seen = 0;
      for (int c = 0; c < 5; c++) begin
        step();
        if (bus.w_r_ptr_upd_o)       upd_seen++;
        if (bus.w_r_ptr_gray_o != 0) gray_seen++;
      end
      chk("arst_no_upd", upd_seen, 0);
      chk("arst_no_gray", gray_seen, 0);
    end

    // Reset with outputs non-zero: flags and registers drop asynchronously
    bus.r_ptr_gray_i = 4'b0001;
    step();
    step();
    step();
    chk("pre_arst2_bin", int'(bus.w_r_ptr_bin_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst2_bin", int'(bus.w_r_ptr_bin_o), 0);
    chk("arst2_gray", int'(bus.w_r_ptr_gray_o), 0);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
